match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 7, meaning the points needed to win (legal range 1..15).
REQ-002 The block SHALL have parameter SERVE_DELAY, default 60, meaning the number of frameTick pulses the ball is held at centre before play (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port frameTick, input, 1 bit: a one-clk pulse per display frame.
REQ-006 The block SHALL have port startBtn, input, 1 bit: the start button, level, synchronous to clk.
REQ-007 The block SHALL have port playerDidScore, input, 2 bits, from ball physics, sticky until physics reset: bit1 = right player scored, bit0 = left player scored.
REQ-008 The block SHALL have port physicsRstN, output, 1 bit: drives the ball-physics reset; low holds the ball at centre and clears its sticky score flags.
REQ-009 The block SHALL have port leftScore, output, 4 bits: left player points.
REQ-010 The block SHALL have port rightScore, output, 4 bits: right player points.
REQ-011 The block SHALL have port gameState, output, 3 bits: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-012 The block SHALL have port winner, output, 2 bits, one-hot: bit1 = right won, bit0 = left won, 00 = no winner.
REQ-013 The block SHALL have port pointPulse, output, 1 bit: high for exactly the one clk spent in POINT.

Function
REQ-014 All outputs SHALL be registered, and every state transition SHALL occur on a clk rising edge.
REQ-015 startEdge SHALL be asserted when startBtn is high in the current cycle and its registered previous value is low.
REQ-016 IDLE: physicsRstN SHALL be 0 and the scores SHALL be held; on startEdge the block SHALL clear the scores, clear the frame counter and go to SERVE.
REQ-017 SERVE: physicsRstN SHALL be 0 and the frame counter SHALL increment on each frameTick.
REQ-018 SERVE: on the frameTick that makes the count equal SERVE_DELAY, the block SHALL go to PLAY and clear the counter.
REQ-019 The SERVE dwell time SHALL be at least 1 clk even when frameTick is held high.
REQ-020 PLAY: physicsRstN SHALL be 1.
REQ-021 PLAY: playerDidScore SHALL be ignored in the first clk after entering PLAY (guard cycle for the physics flags clearing).
REQ-022 PLAY: in any later cycle, if playerDidScore != 00, the block SHALL latch the value and go to POINT.
REQ-023 PLAY: physicsRstN SHALL go to 0 in the cycle after detection.
REQ-024 POINT lasts 1 clk, with physicsRstN = 0 and pointPulse = 1.
REQ-025 POINT, latched 01: leftScore SHALL increment. Latched 10: rightScore SHALL increment. The incremented score SHALL be visible in the clk after POINT.
REQ-026 POINT, latched 11 (simultaneous): the point is a let, neither score changes, and the block SHALL go to SERVE.
REQ-027 POINT: if the incremented score equals WIN_SCORE, the block SHALL go to OVER and set the matching winner bit in the same edge; otherwise it SHALL go to SERVE with the counter cleared.
REQ-028 OVER: physicsRstN SHALL be 0, and the scores and winner SHALL be held.
REQ-029 OVER: on startEdge the block SHALL clear the scores and winner and go to SERVE.
REQ-030 startEdge SHALL be ignored in SERVE, PLAY and POINT.
REQ-031 frameTick SHALL be ignored outside SERVE.
REQ-032 The scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-033 Unused gameState encodings (5..7) SHALL recover to IDLE on the next clk.

Reset
REQ-034 While rst = 0 (asynchronous, at any time including mid-SERVE or mid-POINT), the block SHALL force: state IDLE, physicsRstN = 0, leftScore = 0, rightScore = 0, winner = 00, pointPulse = 0, counter = 0, latched score = 00, previous startBtn = 0.
REQ-035 After rst rises, the block SHALL stay in IDLE until the first startEdge, even if startBtn was held high through reset.

Verification
REQ-036 Reset: rst low mid-SERVE with count 30 -> all outputs at reset values immediately; after rst release, startBtn held high -> remains IDLE until released and pressed again.
REQ-037 Serve timing: startEdge then 60 frameTicks -> physicsRstN rises on the clk after the 60th tick; gameState = 2.
REQ-038 Left point: PLAY, playerDidScore = 01 -> pointPulse 1 clk, physicsRstN low the next clk, leftScore 0 -> 1, gameState = 1.
REQ-039 Simultaneous: PLAY, playerDidScore = 11 -> pointPulse 1 clk, both scores unchanged, SERVE.
REQ-040 Guard cycle: playerDidScore = 10 already high on the first PLAY clk and cleared the next clk -> no point awarded.
REQ-041 Win: rightScore 6, playerDidScore = 10 -> rightScore = 7, winner = 10, gameState = 4, physicsRstN = 0; startEdge -> scores 0, winner 00, SERVE.

Source files
------------

// File: rtl/match_controller.sv
// Pong match sequencer: serve hold, rally, point award and game-over handling.
// Drives the ball-physics reset and keeps both players' scores.
module match_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frameTick,
  input  logic       startBtn,
  input  logic [1:0] playerDidScore,
  output logic       physicsRstN,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic [2:0] gameState,
  output logic [1:0] winner,
  output logic       pointPulse
);

  localparam logic [3:0] WIN_Q   = 4'(WIN_SCORE);
  localparam logic [7:0] DELAY_Q = 8'(SERVE_DELAY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       start_prev_q;
  logic       armed_q, armed_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] latch_q, latch_d;
  logic [3:0] left_q, left_d;
  logic [3:0] right_q, right_d;
  logic [1:0] winner_q, winner_d;
  logic       phys_q, phys_d;
  logic       pulse_q, pulse_d;
  logic       guard_q, guard_d;
  logic       start_edge;

  always_comb begin
    // armed_q blocks a button held through reset from counting as a press
    start_edge = startBtn & ~start_prev_q & armed_q;
    armed_d    = armed_q | ~startBtn;
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_d    = latch_q;
    left_d     = left_q;
    right_d    = right_q;
    winner_d   = winner_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          left_d   = 4'd0;
          right_d  = 4'd0;
          winner_d = 2'b00;
          cnt_d    = 8'd0;
          state_d  = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frameTick) begin
          if (cnt_q + 8'd1 == DELAY_Q) begin
            cnt_d   = 8'd0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        // guard_q masks stale flags while physics comes out of reset
        if (!guard_q && playerDidScore != 2'b00) begin
          latch_d = playerDidScore;
          state_d = S_POINT;
        end
      end
      S_POINT: begin
        state_d = S_SERVE;
        cnt_d   = 8'd0;
        latch_d = 2'b00;
        if (latch_q == 2'b01 && left_q < WIN_Q) begin
          left_d = left_q + 4'd1;
          if (left_d == WIN_Q) begin
            state_d  = S_OVER;
            winner_d = 2'b01;
          end
        end else if (latch_q == 2'b10 && right_q < WIN_Q) begin
          right_d = right_q + 4'd1;
          if (right_d == WIN_Q) begin
            state_d  = S_OVER;
            winner_d = 2'b10;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    phys_d  = (state_d == S_PLAY);
    pulse_d = (state_d == S_POINT);
    guard_d = (state_d == S_PLAY) && (state_q != S_PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      cnt_q        <= 8'd0;
      latch_q      <= 2'b00;
      left_q       <= 4'd0;
      right_q      <= 4'd0;
      winner_q     <= 2'b00;
      phys_q       <= 1'b0;
      pulse_q      <= 1'b0;
      guard_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= startBtn;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      latch_q      <= latch_d;
      left_q       <= left_d;
      right_q      <= right_d;
      winner_q     <= winner_d;
      phys_q       <= phys_d;
      pulse_q      <= pulse_d;
      guard_q      <= guard_d;
    end
  end

  assign physicsRstN = phys_q;
  assign leftScore   = left_q;
  assign rightScore  = right_q;
  assign gameState   = state_q;
  assign winner      = winner_q;
  assign pointPulse  = pulse_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: reset, serve timing, points, guard cycle, let and win.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frameTick;
  logic       startBtn;
  logic [1:0] playerDidScore;
  logic       physicsRstN;
  logic [3:0] leftScore;
  logic [3:0] rightScore;
  logic [2:0] gameState;
  logic [1:0] winner;
  logic       pointPulse;

  int n_vec = 0;
  int n_err = 0;

  match_controller #(.WIN_SCORE(7), .SERVE_DELAY(60)) dut (
    .clk            (clk),
    .rst            (rst),
    .frameTick      (frameTick),
    .startBtn       (startBtn),
    .playerDidScore (playerDidScore),
    .physicsRstN    (physicsRstN),
    .leftScore      (leftScore),
    .rightScore     (rightScore),
    .gameState      (gameState),
    .winner         (winner),
    .pointPulse     (pointPulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n one-clk frameTick pulses, each preceded by an idle clk
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frameTick = 1'b0;
      step();
      frameTick = 1'b1;
      step();
    end
    frameTick = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    frameTick = 1'b0;
    startBtn = 1'b0;
    playerDidScore = 2'b00;
    #12;
    check("rst_state", 32'(gameState), 0);
    check("rst_phys", 32'(physicsRstN), 0);
    check("rst_winner", 32'(winner), 0);
    #11 rst = 1'b1;
    step();
    startBtn = 1'b1;
    step();
    check("start_serve", 32'(gameState), 1);
    check("serve_phys", 32'(physicsRstN), 0);

    // asynchronous reset in the middle of a serve
    ticks(30);
    #3 rst = 1'b0;
    #1;
    check("midrst_state", 32'(gameState), 0);
    check("midrst_phys", 32'(physicsRstN), 0);
    check("midrst_pulse", 32'(pointPulse), 0);
    check("midrst_left", 32'(leftScore), 0);
    check("midrst_right", 32'(rightScore), 0);
    #7 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("held_btn_idle", 32'(gameState), 0);
    end
    startBtn = 1'b0;
    step();
    check("released_idle", 32'(gameState), 0);
    startBtn = 1'b1;
    step();
    check("repress_serve", 32'(gameState), 1);

    // serve timing: PLAY only after the 60th tick
    ticks(59);
    check("tick59_state", 32'(gameState), 1);
    check("tick59_phys", 32'(physicsRstN), 0);
    ticks(1);
    check("tick60_state", 32'(gameState), 2);
    check("tick60_phys", 32'(physicsRstN), 1);

    // left point
    step();
    check("play_guard", 32'(gameState), 2);
    playerDidScore = 2'b01;
    step();
    check("lpt_state", 32'(gameState), 3);
    check("lpt_pulse", 32'(pointPulse), 1);
    check("lpt_phys", 32'(physicsRstN), 0);
    check("lpt_left_before", 32'(leftScore), 0);
    playerDidScore = 2'b00;
    step();
    check("lpt_after_state", 32'(gameState), 1);
    check("lpt_after_pulse", 32'(pointPulse), 0);
    check("lpt_left", 32'(leftScore), 1);
    check("lpt_right", 32'(rightScore), 0);

    // stale flag on the first PLAY clk must be ignored
    ticks(60);
    playerDidScore = 2'b10;
    step();
    check("guard_state1", 32'(gameState), 2);
    playerDidScore = 2'b00;
    step();
    check("guard_state2", 32'(gameState), 2);
    check("guard_right", 32'(rightScore), 0);
    check("guard_phys", 32'(physicsRstN), 1);

    // simultaneous score is a let
    playerDidScore = 2'b11;
    step();
    check("let_state", 32'(gameState), 3);
    check("let_pulse", 32'(pointPulse), 1);
    playerDidScore = 2'b00;
    step();
    check("let_after_state", 32'(gameState), 1);
    check("let_left", 32'(leftScore), 1);
    check("let_right", 32'(rightScore), 0);

    // start press is ignored during SERVE
    startBtn = 1'b0;
    step();
    startBtn = 1'b1;
    step();
    check("serve_ignores_start", 32'(gameState), 1);

    // bring right to 6
    for (int i = 0; i < 6; i++) begin
      ticks(60);
      step();
      playerDidScore = 2'b10;
      step();
      playerDidScore = 2'b00;
      step();
      check("rpt_right", 32'(rightScore), 32'(i + 1));
    end
    check("rpt_state", 32'(gameState), 1);

    // winning point
    ticks(60);
    step();
    playerDidScore = 2'b10;
    step();
    check("win_point_state", 32'(gameState), 3);
    playerDidScore = 2'b00;
    step();
    check("win_state", 32'(gameState), 4);
    check("win_right", 32'(rightScore), 7);
    check("win_left", 32'(leftScore), 1);
    check("win_winner", 32'(winner), 2);
    check("win_phys", 32'(physicsRstN), 0);
    ticks(3);
    check("over_ignores_tick", 32'(gameState), 4);
    check("over_hold_winner", 32'(winner), 2);

    // restart from OVER
    startBtn = 1'b0;
    step();
    startBtn = 1'b1;
    step();
    check("restart_state", 32'(gameState), 1);
    check("restart_left", 32'(leftScore), 0);
    check("restart_right", 32'(rightScore), 0);
    check("restart_winner", 32'(winner), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
